// File: rtl/riscorvo_mem_arbiter.sv
// Shares one single-port memory bus between the riscorvo instruction-fetch and
// data ports, one outstanding transaction at a time.
//
// state  | meaning
// IDLE   | no transaction outstanding, memory bus driven to zero
// BUSY_I | fetch granted, waiting for mem_ready_i
// BUSY_D | load/store granted, waiting for mem_ready_i
module riscorvo_mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    instr_valid_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_ready_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_valid_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] data_mask_i,
  output logic                    data_ready_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_valid_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_mask_o,
  input  logic                    mem_ready_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic       done;
  logic       instr_wait;
  logic       data_first;
  logic       take_instr;
  logic       take_data;

  assign done = (state != IDLE) && mem_ready_i;
  // A fetch being completed this cycle is not a waiting fetch.
  assign instr_wait = instr_valid_i && (state != BUSY_I);
  assign data_first = (DATA_PRIORITY != 0) && (starve_cnt < LIMIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (instr_valid_i && data_valid_i) state_nxt = data_first ? BUSY_D : BUSY_I;
        else if (data_valid_i)             state_nxt = BUSY_D;
        else if (instr_valid_i)            state_nxt = BUSY_I;
      end
      BUSY_I:  if (mem_ready_i) state_nxt = data_valid_i ? BUSY_D : IDLE;
      BUSY_D:  if (mem_ready_i) state_nxt = instr_valid_i ? BUSY_I : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign take_instr = (state_nxt == BUSY_I) && (state != BUSY_I);
  assign take_data  = (state_nxt == BUSY_D) && (state != BUSY_D);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (take_instr)
        starve_cnt <= 4'd0;
      else if (take_data && instr_wait && (starve_cnt < LIMIT))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign grant_o     = {state == BUSY_D, state == BUSY_I};
  assign mem_valid_o = (state != IDLE);

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_mask_o  = '0;
    case (state)
      BUSY_I: begin
        mem_addr_o = instr_addr_i;
        mem_mask_o = '1;
      end
      BUSY_D: begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_wdata_o = data_wdata_i;
        mem_mask_o  = data_mask_i;
      end
      default: ;
    endcase
  end

  assign instr_ready_o = (state == BUSY_I) && mem_ready_i;
  assign data_ready_o  = (state == BUSY_D) && mem_ready_i;
  assign instr_rdata_o = done ? mem_rdata_i : '0;
  assign data_rdata_o  = done ? mem_rdata_i : '0;

endmodule

// File: tb/tb_riscorvo_mem_arbiter.sv
// Directed bench for riscorvo_mem_arbiter: a data-priority instance with a
// starvation limit of 1 and an instruction-priority instance share the stimulus.
module tb_riscorvo_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instr_addr;
  logic        data_valid;
  logic [31:0] data_addr;
  logic        data_we;
  logic [31:0] data_wdata;
  logic [3:0]  data_mask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        instr_ready, data_ready, mem_valid, mem_we;
  logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [1:0]  grant;

  logic        d0_instr_ready, d0_data_ready, d0_mem_valid, d0_mem_we;
  logic [31:0] d0_instr_rdata, d0_data_rdata, d0_mem_addr, d0_mem_wdata;
  logic [3:0]  d0_mem_mask;
  logic [1:0]  d0_grant;

  int checks = 0;
  int errors = 0;

  riscorvo_mem_arbiter #(.DATA_PRIORITY(1), .STARVE_LIMIT(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid_i(instr_valid), .instr_addr_i(instr_addr),
    .instr_ready_o(instr_ready), .instr_rdata_o(instr_rdata),
    .data_valid_i(data_valid), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_wdata_i(data_wdata), .data_mask_i(data_mask),
    .data_ready_o(data_ready), .data_rdata_o(data_rdata),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_mask_o(mem_mask),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .grant_o(grant)
  );

  riscorvo_mem_arbiter #(.DATA_PRIORITY(0), .STARVE_LIMIT(4)) u_dut_p0 (
    .clk(clk), .reset_n(reset_n),
    .instr_valid_i(instr_valid), .instr_addr_i(instr_addr),
    .instr_ready_o(d0_instr_ready), .instr_rdata_o(d0_instr_rdata),
    .data_valid_i(data_valid), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_wdata_i(data_wdata), .data_mask_i(data_mask),
    .data_ready_o(d0_data_ready), .data_rdata_o(d0_data_rdata),
    .mem_valid_o(d0_mem_valid), .mem_addr_o(d0_mem_addr), .mem_we_o(d0_mem_we),
    .mem_wdata_o(d0_mem_wdata), .mem_mask_o(d0_mem_mask),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .grant_o(d0_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: time %0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid = 1'b0; instr_addr = '0;
    data_valid  = 1'b0; data_addr  = '0; data_we = 1'b0;
    data_wdata  = '0;   data_mask  = '0;
    mem_ready   = 1'b0; mem_rdata  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #3;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || grant !== 2'b00 || mem_addr !== 32'h0 || mem_mask !== 4'h0) begin
      errors++;
      $display("FAIL reset_bus: valid=%b grant=%b addr=%h mask=%h required 0/00/0/0",
               mem_valid, grant, mem_addr, mem_mask);
    end
    checks++;
    if (instr_ready !== 1'b0 || data_ready !== 1'b0 || instr_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_resp: irdy=%b drdy=%b irdata=%h drdata=%h required all 0",
               instr_ready, data_ready, instr_rdata, data_rdata);
    end
    checks++;
    if (d0_mem_valid !== 1'b0 || d0_grant !== 2'b00 || d0_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_p0: valid=%b grant=%b drdy=%b required 0/00/0",
               d0_mem_valid, d0_grant, d0_data_ready);
    end
    next_cycle();
    reset_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single_fetch();
    do_reset();
    instr_valid = 1'b1; instr_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL fetch_c0: valid=%b grant=%b required 0/00", mem_valid, grant);
    end
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_mask !== 4'hF || mem_we !== 1'b0 ||
        grant !== 2'b01) begin
      errors++;
      $display("FAIL fetch_bus: valid=%b addr=%h mask=%h we=%b grant=%b required 1/100/f/0/01",
               mem_valid, mem_addr, mem_mask, mem_we, grant);
    end
    checks++;
    if (instr_ready !== 1'b1 || instr_rdata !== 32'h13 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp: irdy=%b irdata=%h drdy=%b required 1/00000013/0",
               instr_ready, instr_rdata, data_ready);
    end
    // Second fetch held straight after completion must see one idle cycle.
    next_cycle();
    mem_ready = 1'b0; mem_rdata = '0; instr_addr = 32'h104;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || mem_valid !== 1'b0 || instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gap: grant=%b valid=%b irdy=%b required 00/0/0", grant, mem_valid, instr_ready);
    end
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || mem_addr !== 32'h104 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL fetch_second: grant=%b addr=%h irdy=%b required 01/104/1", grant, mem_addr, instr_ready);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    instr_valid = 1'b1; instr_addr = 32'h200;
    data_valid = 1'b1; data_addr = 32'h8000_0000; data_we = 1'b1;
    data_wdata = 32'hDEAD_BEEF; data_mask = 4'h3;
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h55;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || mem_addr !== 32'h8000_0000 || mem_we !== 1'b1 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_mask !== 4'h3) begin
      errors++;
      $display("FAIL simul_data: grant=%b addr=%h we=%b wdata=%h mask=%h required 10/80000000/1/deadbeef/3",
               grant, mem_addr, mem_we, mem_wdata, mem_mask);
    end
    checks++;
    if (data_ready !== 1'b1 || instr_ready !== 1'b0 || data_rdata !== 32'h55) begin
      errors++;
      $display("FAIL simul_dresp: drdy=%b irdy=%b drdata=%h required 1/0/55", data_ready, instr_ready, data_rdata);
    end
    next_cycle();
    data_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || mem_valid !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0 ||
        mem_wdata !== 32'h0 || mem_mask !== 4'hF) begin
      errors++;
      $display("FAIL simul_instr: grant=%b valid=%b addr=%h we=%b wdata=%h mask=%h required 01/1/200/0/0/f",
               grant, mem_valid, mem_addr, mem_we, mem_wdata, mem_mask);
    end
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h66;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || instr_rdata !== 32'h66 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_iresp: irdy=%b irdata=%h drdy=%b required 1/66/0", instr_ready, instr_rdata, data_ready);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_idle: grant=%b valid=%b required 00/0", grant, mem_valid);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    // Limit is 1: after one data grant past a waiting fetch, a tie goes to the fetch.
    do_reset();
    instr_valid = 1'b1; instr_addr = 32'h300;
    data_valid = 1'b1; data_addr = 32'h20; data_we = 1'b0;
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL starve_first: grant=%b required 10", grant);
    end
    next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    mem_ready = 1'b0;
    instr_valid = 1'b1; instr_addr = 32'h300;
    data_valid = 1'b1; data_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL starve_idle: grant=%b required 00", grant);
    end
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || mem_addr !== 32'h300 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL starve_instr: grant=%b addr=%h irdy=%b required 01/300/1", grant, mem_addr, instr_ready);
    end
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || mem_addr !== 32'h40 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL starve_data: grant=%b addr=%h drdy=%b required 10/40/1", grant, mem_addr, data_ready);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_wait_states();
    int valid_cycles;
    int pulses;
    do_reset();
    valid_cycles = 0;
    pulses = 0;
    data_valid = 1'b1; data_addr = 32'h1234; data_we = 1'b0; data_mask = 4'hF;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (i == 5) begin
        mem_ready = 1'b1; mem_rdata = 32'hCAFE;
      end
      @(negedge clk);
      if (mem_valid === 1'b1 && mem_addr === 32'h1234) valid_cycles++;
      if (data_ready === 1'b1) pulses++;
      checks++;
      if (instr_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_irdy: cycle %0d irdy=%b required 0", i, instr_ready);
      end
    end
    checks++;
    if (data_rdata !== 32'hCAFE) begin
      errors++;
      $display("FAIL wait_rdata: drdata=%h required 0000cafe", data_rdata);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    if (data_ready === 1'b1) pulses++;
    checks++;
    if (valid_cycles !== 6 || pulses !== 1 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_counts: valid_cycles=%0d pulses=%0d valid_after=%b required 6/1/0",
               valid_cycles, pulses, mem_valid);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_valid = 1'b1; data_addr = 32'h50; data_we = 1'b1; data_mask = 4'h1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: grant=%b valid=%b required 10/1", grant, mem_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || grant !== 2'b00 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b grant=%b addr=%h we=%b required 0/00/0/0",
               mem_valid, grant, mem_addr, mem_we);
    end
    next_cycle();
    reset_n = 1'b1;
    data_valid = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b0 || instr_ready !== 1'b0 || data_rdata !== 32'h0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stale: drdy=%b irdy=%b drdata=%h valid=%b required 0/0/0/0",
               data_ready, instr_ready, data_rdata, mem_valid);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_priority0();
    do_reset();
    instr_valid = 1'b1; instr_addr = 32'h400;
    data_valid = 1'b1; data_addr = 32'h900; data_we = 1'b1;
    data_wdata = 32'h1234_5678; data_mask = 4'hC;
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h88;
    @(negedge clk);
    checks++;
    if (d0_grant !== 2'b01 || d0_mem_addr !== 32'h400 || d0_instr_ready !== 1'b1 || d0_mem_mask !== 4'hF) begin
      errors++;
      $display("FAIL p0_instr: grant=%b addr=%h irdy=%b mask=%h required 01/400/1/f",
               d0_grant, d0_mem_addr, d0_instr_ready, d0_mem_mask);
    end
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (d0_grant !== 2'b10 || d0_mem_addr !== 32'h900 || d0_mem_we !== 1'b1 ||
        d0_mem_wdata !== 32'h1234_5678 || d0_mem_mask !== 4'hC || d0_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL p0_data: grant=%b addr=%h we=%b wdata=%h mask=%h drdy=%b required 10/900/1/12345678/c/1",
               d0_grant, d0_mem_addr, d0_mem_we, d0_mem_wdata, d0_mem_mask, d0_data_ready);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (d0_grant !== 2'b00 || d0_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL p0_idle: grant=%b valid=%b required 00/0", d0_grant, d0_mem_valid);
    end
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_reset_mid();
    test_priority0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
